// File: rtl/spi_pkg.sv
// +--------------------------------------------------------------------+
// | spi_pkg: shared SPI link constants and the responder state type.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam logic [SPI_DATA_W-1:0] SPI_IDLE_FILL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_slave_txbuf.sv
// +--------------------------------------------------------------------+
// | spi_slave_txbuf: one-deep valid/ready holding register for the     |
// | next word the responder will shift out.   Rev 1.0                  |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_slave_txbuf
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              spi_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              consume,
  output logic              tx_ready,
  output logic              tx_pending,
  output logic [DATA_W-1:0] tx_buf
);

  logic              r_pending;
  logic [DATA_W-1:0] r_buf;

  // An accept on the same edge as a consume wins: the consumer sampled
  // the empty buffer, so the new word is kept for the following frame.
  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_buf     <= '0;
    end else begin
      if (consume)
        r_pending <= 1'b0;
      if (tx_valid && !r_pending) begin
        r_pending <= 1'b1;
        r_buf     <= tx_data;
      end
    end
  end

  assign tx_ready   = !r_pending;
  assign tx_pending = r_pending;
  assign tx_buf     = r_buf;

endmodule

`default_nettype wire

// File: rtl/spi_slave.sv
// +--------------------------------------------------------------------+
// | spi_slave: SPI responder, full-duplex DATA_W-bit frames on spi_clk.|
// | Option: SPI_SLAVE_LSB_FIRST_EN selects LSB-first shifting.  Rev 1.0|
// +--------------------------------------------------------------------+
`default_nettype none

module spi_slave
  import spi_pkg::*;
#(
  parameter int                DATA_W    = SPI_DATA_W,
  parameter logic [DATA_W-1:0] IDLE_FILL = DATA_W'(SPI_IDLE_FILL)
) (
  input  logic              spi_clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err,
  output logic              tx_underrun
);

  localparam int                c_CNT_W = $clog2(DATA_W) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);

  spi_state_e         r_state;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [DATA_W-1:0]  r_tx_shift;
  logic [DATA_W-1:0]  r_rx_shift;
  logic [DATA_W-1:0]  r_rx_data;
  logic               r_miso;
  logic               r_rx_valid;
  logic               r_overrun;
  logic               r_frame_err;
  logic               r_tx_underrun;

  logic               w_load;
  logic               w_tx_pending;
  logic [DATA_W-1:0]  w_tx_buf;
  logic [DATA_W-1:0]  w_load_word;
  logic               w_load_miso;
  logic [DATA_W-1:0]  w_load_shift;
  logic               w_next_miso;
  logic [DATA_W-1:0]  w_tx_shift_nxt;
  logic [DATA_W-1:0]  w_rx_shift_nxt;

  assign w_load      = (r_state == ST_IDLE) && !ss_n;
  assign w_load_word = w_tx_pending ? w_tx_buf : IDLE_FILL;

  // The first bit goes straight to miso at load; the shifter keeps the rest
  // and back-fills zeros, so miso drops to 0 once the word is exhausted.
`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign w_load_miso    = w_load_word[0];
  assign w_load_shift   = w_load_word >> 1;
  assign w_next_miso    = r_tx_shift[0];
  assign w_tx_shift_nxt = r_tx_shift >> 1;
  assign w_rx_shift_nxt = {mosi, r_rx_shift[DATA_W-1:1]};
`else
  assign w_load_miso    = w_load_word[DATA_W-1];
  assign w_load_shift   = w_load_word << 1;
  assign w_next_miso    = r_tx_shift[DATA_W-1];
  assign w_tx_shift_nxt = r_tx_shift << 1;
  assign w_rx_shift_nxt = {r_rx_shift[DATA_W-2:0], mosi};
`endif

  spi_slave_txbuf #(
    .DATA_W (DATA_W)
  ) u_txbuf (
    .spi_clk    (spi_clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .consume    (w_load),
    .tx_ready   (tx_ready),
    .tx_pending (w_tx_pending),
    .tx_buf     (w_tx_buf)
  );

  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_miso        <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_err   <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_frame_err   <= 1'b0;
      r_tx_underrun <= 1'b0;
      if (rx_ack && r_rx_valid) begin
        r_rx_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (!ss_n) begin
            r_tx_shift    <= w_load_shift;
            r_miso        <= w_load_miso;
            r_tx_underrun <= !w_tx_pending;
            r_bit_cnt     <= '0;
            r_state       <= ST_SHIFT;
          end else begin
            r_miso <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (ss_n) begin
            r_rx_shift  <= '0;
            r_frame_err <= 1'b1;
            r_miso      <= 1'b0;
            r_bit_cnt   <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_rx_shift <= w_rx_shift_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_miso     <= w_next_miso;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == c_LAST)
              r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // A same-edge ack retires the old word; the new one stays valid.
          r_rx_data  <= r_rx_shift;
          r_rx_valid <= 1'b1;
          if (r_rx_valid && !rx_ack)
            r_overrun <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign miso        = r_miso;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = (r_state != ST_IDLE);
  assign overrun     = r_overrun;
  assign frame_err   = r_frame_err;
  assign tx_underrun = r_tx_underrun;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// +--------------------------------------------------------------------+
// | tb_spi_slave: directed, table-driven self-checking bench for       |
// | spi_slave (follows SPI_SLAVE_LSB_FIRST_EN when defined).  Rev 1.0  |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_spi_slave;

  logic       spi_clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ack = 1'b0;
  logic       miso, tx_ready, rx_valid, busy, overrun, frame_err, tx_underrun;
  logic [7:0] rx_data;

  int checks = 0;
  int errors = 0;

  spi_slave #(
    .DATA_W    (8),
    .IDLE_FILL (8'hFF)
  ) dut (
    .spi_clk     (spi_clk),
    .rst         (rst),
    .ss_n        (ss_n),
    .mosi        (mosi),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .busy        (busy),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .tx_underrun (tx_underrun)
  );

  always #5 spi_clk = ~spi_clk;

  // tx_mode: 0 = no word offered, 1 = accepted before the frame, 2 = offered on the load edge
  typedef struct {
    int         tx_mode;
    logic [7:0] tx_word;
    logic [7:0] mosi_word;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    logic       exp_under;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge spi_clk);
    #1;
  endtask

  // word bit index of the k-th bit on the wire
  function automatic int bidx(input int k);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return k;
`else
    return 7 - k;
`endif
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_miso"}, miso, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_tx_ready"}, tx_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_tx_underrun"}, tx_underrun, 0);
  endtask

  task automatic run_frame(input vec_t v, input logic ack_at_done);
    logic [7:0] got;
    got = 8'h00;
    if (v.tx_mode == 1) begin
      tx_data = v.tx_word; tx_valid = 1'b1;
      tick;
      tx_valid = 1'b0;
      chk("tx_ready_after_accept", tx_ready, 0);
    end
    if (v.tx_mode == 2) begin
      tx_data = v.tx_word; tx_valid = 1'b1;
    end
    ss_n = 1'b0;
    tick;                                   // E0 load
    tx_valid = 1'b0;
    chk("tx_underrun_E0", tx_underrun, v.exp_under);
    chk("tx_ready_E0", tx_ready, v.tx_mode != 2);
    chk("busy_E0", busy, 1);
    got[bidx(0)] = miso;
    for (int k = 1; k <= 8; k++) begin
      mosi = v.mosi_word[bidx(k - 1)];
      tick;                                 // Ek
      if (k < 8) got[bidx(k)] = miso;
    end
    chk("miso_word", got, v.exp_miso);
    chk("miso_after_E8", miso, 0);
    ss_n = 1'b1;
    rx_ack = ack_at_done;
    tick;                                   // E9 done
    rx_ack = 1'b0;
    chk("rx_valid_E9", rx_valid, 1);
    chk("rx_data_E9", rx_data, v.exp_rx);
    chk("busy_E9", busy, 0);
  endtask

  task automatic ack_clear;
    rx_ack = 1'b1;
    tick;
    rx_ack = 1'b0;
    chk("rx_valid_after_ack", rx_valid, 0);
    chk("overrun_after_ack", overrun, 0);
  endtask

  initial begin
    vecs[0] = '{1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b0};
    vecs[1] = '{0, 8'h00, 8'h81, 8'hFF, 8'h81, 1'b1};
    vecs[2] = '{2, 8'h5A, 8'hC3, 8'hFF, 8'hC3, 1'b1};   // word offered on the load edge is held
    vecs[3] = '{0, 8'h00, 8'h01, 8'h5A, 8'h01, 1'b0};   // held word goes out now
    vecs[4] = '{1, 8'h01, 8'h01, 8'h01, 8'h01, 1'b0};

    #2;
    reset_checks("reset");
    #10;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i], 1'b0);
      ack_clear;
    end

    // overrun: two frames without ack
    run_frame('{0, 8'h00, 8'h11, 8'hFF, 8'h11, 1'b1}, 1'b0);
    chk("overrun_first", overrun, 0);
    run_frame('{0, 8'h00, 8'h22, 8'hFF, 8'h22, 1'b1}, 1'b0);
    chk("overrun_second", overrun, 1);
    ack_clear;

    // ack on the same edge as DONE: new word valid, no overrun
    run_frame('{0, 8'h00, 8'h33, 8'hFF, 8'h33, 1'b1}, 1'b0);
    run_frame('{0, 8'h00, 8'h44, 8'hFF, 8'h44, 1'b1}, 1'b1);
    chk("overrun_ack_at_done", overrun, 0);
    ack_clear;

    // abort after E4
    ss_n = 1'b0;
    tick;
    for (int k = 0; k < 4; k++) begin
      mosi = 1'b1;
      tick;
    end
    ss_n = 1'b1;
    tick;
    chk("frame_err_pulse", frame_err, 1);
    chk("busy_after_abort", busy, 0);
    chk("miso_after_abort", miso, 0);
    tick;
    chk("frame_err_one_cycle", frame_err, 0);
    chk("rx_valid_after_abort", rx_valid, 0);
    run_frame('{1, 8'hC6, 8'h9E, 8'hC6, 8'h9E, 1'b0}, 1'b0);
    ack_clear;

    // asynchronous reset mid-SHIFT with rx_valid set and a word pending
    run_frame('{0, 8'h00, 8'h77, 8'hFF, 8'h77, 1'b1}, 1'b0);
    ss_n = 1'b0;
    tick;
    tx_data = 8'hAB; tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    tick;
    chk("tx_ready_before_rst", tx_ready, 0);
    chk("miso_before_rst", miso, 1);
    #2;
    rst = 1'b1;
    #1;
    reset_checks("async_rst");
    ss_n = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    chk("frame_err_after_rst", frame_err, 0);
    chk("tx_ready_after_rst", tx_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI responder (slave) end of the team's SPI link, running entirely in the spi_clk domain driven by the initiator.
- Detects frame start on active-low slave select.
- Shifts in DATA_W bits from MOSI while shifting out a preloaded word on MISO.
- Presents each received word to local logic with a valid/ack handshake.
- Accepts the next transmit word through a one-deep valid/ready buffer.

Parameters:
DATA_W, 8, frame length in bits and width of tx/rx data.
IDLE_FILL, 8'hFF, word shifted out on MISO when no transmit word is pending (width DATA_W).

Ports:
spi_clk  in  1  SPI clock from initiator; all logic on rising edge.
rst  in  1  reset.
ss_n  in  1  slave select, active low.
mosi  in  1  serial data from initiator.
miso  out  1  serial data to initiator.
tx_data  in  DATA_W  next word to transmit.
tx_valid  in  1  tx_data valid.
tx_ready  out  1  transmit buffer empty; a word is accepted on an edge with tx_valid & tx_ready.
rx_data  out  DATA_W  last received word.
rx_valid  out  1  rx_data holds an unacknowledged word.
rx_ack  in  1  local logic consumed rx_data.
busy  out  1  frame in progress (state SHIFT or DONE).
overrun  out  1  sticky: a frame completed while rx_valid was still 1.
frame_err  out  1  one-cycle pulse: ss_n rose before the frame finished.
tx_underrun  out  1  one-cycle pulse: frame started with no word pending, so IDLE_FILL was sent.

Behaviour:
- Reset: rst is asynchronous and active-high; clock is spi_clk. Reset values:
  - outputs: miso=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0, overrun=0, frame_err=0, tx_underrun=0
  - internal: state=IDLE, bit_cnt=0, shift registers cleared, tx_pending=0
- Reset mid-frame aborts the frame with no frame_err pulse; any pending tx word is lost.
- States: IDLE, SHIFT, DONE.
- IDLE, ss_n=1: hold; miso=0.
- IDLE, ss_n=0 (load edge E0):
  - tx_shift <= tx_buf if tx_pending, else IDLE_FILL with a tx_underrun pulse.
  - tx_pending <= 0; miso <= MSB of the loaded word; bit_cnt <= 0; go to SHIFT.
- SHIFT, ss_n=0, edges E1..E_DATA_W:
  - rx_shift <= {rx_shift[DATA_W-2:0], mosi}.
  - miso <= next bit of tx_shift; miso=0 once all bits are sent.
  - bit_cnt++; at the edge where bit_cnt==DATA_W-1, go to DONE.
- SHIFT, ss_n=1 on any edge: go to IDLE; rx_shift is discarded; frame_err pulses one cycle; miso <= 0. The consumed tx word is not restored.
- DONE (edge E_DATA_W+1): rx_data <= rx_shift; rx_valid <= 1; if rx_valid was already 1 and rx_ack=0, set overrun. Always go to IDLE; ss_n is ignored in DONE.
- Latency: rx_valid rises after edge DATA_W+1 counted from the load edge.
- Back-to-back frames with ss_n held low are separated by exactly one DONE edge plus one IDLE load edge.
- rx handshake:
  - rx_ack with rx_valid=1 clears rx_valid and clears overrun.
  - rx_ack on the same edge as DONE: the new word wins, rx_valid stays 1, no overrun.
- tx handshake:
  - tx_ready = !tx_pending.
  - Accept sets tx_pending and captures tx_buf.
  - Accept on the same edge as a load: the load already sampled tx_pending=0 and sends IDLE_FILL; the accepted word is held for the next frame.
- Widths: bit_cnt is clog2(DATA_W)+1 bits, with no wrap inside a frame.

Optional Feature:
SPI_SLAVE_LSB_FIRST_EN
- Defined: both directions LSB first. miso starts with tx word bit 0; rx_shift shifts right, with mosi entering the MSB.
- Undefined: MSB first as described above.
- Timing, handshakes and flags are identical in both modes.

Decomposition:
- Package spi_pkg holds:
  - state enum (IDLE, SHIFT, DONE)
  - SPI_DATA_W default constant, shared with the SPI master
  - SPI_IDLE_FILL constant
- One natural sub-module: spi_slave_txbuf, the one-deep valid/ready holding register providing tx_pending, tx_buf and tx_ready.

Test Plan:
- Reset then tx_data=8'hA5 accepted; ss_n low; mosi drives 8'h3C over E1..E8 -> miso bits 1,0,1,0,0,1,0,1 after E0..E7; rx_data=8'h3C with rx_valid=1 after E9; tx_ready=1 again after E0.
- No tx word; run a frame with mosi=8'h81 -> tx_underrun pulse at E0; miso shows 8'hFF; rx_data=8'h81.
- Two frames with rx_ack held 0 -> overrun=1 after the second DONE; rx_data holds the second word; rx_ack clears rx_valid and overrun.
- ss_n raised after E4 -> frame_err pulse; rx_valid stays 0; state returns to IDLE; the next full frame receives correctly.
- rst asserted mid-SHIFT -> all outputs return to reset values asynchronously; no frame_err pulse.
- With SPI_SLAVE_LSB_FIRST_EN, tx=8'h01 and mosi bits 1,0,0,0,0,0,0,0 -> miso first bit=1; rx_data=8'h01.
